// File: rtl/boton_debounce.sv
// -----------------------------------------------------------------------------
// boton_debounce
//
// Input conditioning for the four board push-buttons. Each raw pin is brought
// into the CLK domain through a two-flop synchroniser and then debounced: a new
// level is only accepted once it has been seen for DEBOUNCE_CYCLES consecutive
// cycles. The clean level is presented in the same polarity as the raw pin so
// the block can sit transparently in front of the LED stage. One-cycle
// press/release strobes are produced for downstream counters and FSMs.
//
// Parameters:
//   DEBOUNCE_CYCLES : consecutive stable cycles needed to accept a change
//                     (legal range 2 .. 2**20)
//   ACTIVE_LOW      : per-button polarity, bit i = 1 -> button i reads 0
//                     when pressed
//
// Ports:
//   CLK        in   system clock, rising edge
//   RSTN       in   asynchronous active-low reset (release synchronised
//                   externally to CLK)
//   BOTON_RAW  in   [3:0] raw asynchronous button pins
//   BOTON      out  [3:0] debounced level, raw-pin polarity
//   PRESS      out  [3:0] one-cycle strobe when button i becomes pressed
//   RELEASE    out  [3:0] one-cycle strobe when button i becomes released
// -----------------------------------------------------------------------------
module boton_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 120000,
  parameter logic [3:0]  ACTIVE_LOW      = 4'b0111
) (
  input  logic       CLK,
  input  logic       RSTN,
  input  logic [3:0] BOTON_RAW,
  output logic [3:0] BOTON,
  output logic [3:0] PRESS,
  output logic [3:0] RELEASE
);

  // Counter only has to reach DEBOUNCE_CYCLES-1, so $clog2 is exactly wide
  // enough and the count can never wrap.
  localparam int unsigned     CNT_W    = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // The channel state is not stored: it is implied by whether the
  // synchronised input disagrees with the accepted level.
  typedef enum logic {
    ST_STABLE  = 1'b0,
    ST_CONFIRM = 1'b1
  } ch_state_t;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_ch
      // Level the pin shows when the button is not pressed.
      localparam logic rel_lvl = ACTIVE_LOW[gi];

      logic             s1_reg;
      logic             s2_reg;
      logic             stb_reg;
      logic             stb_next;
      logic [CNT_W-1:0] cnt_reg;
      logic [CNT_W-1:0] cnt_next;
      logic             press_reg;
      logic             press_next;
      logic             release_reg;
      logic             release_next;
      ch_state_t        state;

      // State register. s1 is the only flop allowed to go metastable; nothing
      // but s2 ever looks at it.
      always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
          s1_reg      <= rel_lvl;
          s2_reg      <= rel_lvl;
          stb_reg     <= rel_lvl;
          cnt_reg     <= '0;
          press_reg   <= 1'b0;
          release_reg <= 1'b0;
        end else begin
          s1_reg      <= BOTON_RAW[gi];
          s2_reg      <= s1_reg;
          stb_reg     <= stb_next;
          cnt_reg     <= cnt_next;
          press_reg   <= press_next;
          release_reg <= release_next;
        end
      end

      // Next-state logic. Any cycle in which s2 agrees with the accepted
      // level drops the count back to zero, so a bounce never leaves a
      // partial count behind for the next excursion.
      always_comb begin
        stb_next     = stb_reg;
        cnt_next     = '0;
        press_next   = 1'b0;
        release_next = 1'b0;
        state        = (s2_reg == stb_reg) ? ST_STABLE : ST_CONFIRM;

        case (state)
          ST_STABLE: begin
            cnt_next = '0;
          end
          ST_CONFIRM: begin
            if (cnt_reg == CNT_LAST) begin
              // Accept: the new level becomes the stable level and exactly
              // one of the two strobes fires, depending on direction.
              stb_next     = s2_reg;
              cnt_next     = '0;
              press_next   = (s2_reg != rel_lvl);
              release_next = (s2_reg == rel_lvl);
            end else begin
              cnt_next = cnt_reg + CNT_W'(1);
            end
          end
          default: begin
            cnt_next = '0;
          end
        endcase
      end

      assign BOTON[gi]   = stb_reg;
      assign PRESS[gi]   = press_reg;
      assign RELEASE[gi] = release_reg;
    end
  endgenerate

endmodule

// File: tb/tb_boton_debounce.sv
module tb_boton_debounce;

  localparam int         D  = 4;
  localparam logic [3:0] AL = 4'b0111;

  logic       CLK = 1'b0;
  logic       RSTN = 1'b0;
  logic [3:0] BOTON_RAW = 4'b0000;
  logic [3:0] BOTON;
  logic [3:0] PRESS;
  logic [3:0] RELEASE;

  int vectors = 0;
  int miscompares = 0;

  int press_seen[4];
  int release_seen[4];

  always #5 CLK = ~CLK;

  boton_debounce #(
    .DEBOUNCE_CYCLES(D),
    .ACTIVE_LOW     (AL)
  ) dut (
    .CLK      (CLK),
    .RSTN     (RSTN),
    .BOTON_RAW(BOTON_RAW),
    .BOTON    (BOTON),
    .PRESS    (PRESS),
    .RELEASE  (RELEASE)
  );

  // Reference model: keep the history of pin values sampled at each edge.
  // The synchroniser delays a sample by two edges, so at edge e the level
  // flips when the samples taken at edges e-2 .. e-D-1 all show the opposite
  // of the current accepted level.
  logic [3:0] hist[$];
  logic [3:0] m_boton;
  logic [3:0] m_press;
  logic [3:0] m_release;

  always @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      hist.delete();
      for (int i = 0; i < D + 2; i++) hist.push_front(AL);
      m_boton   = AL;
      m_press   = 4'b0000;
      m_release = 4'b0000;
    end else begin
      hist.push_front(BOTON_RAW);
      while (hist.size() > D + 2) void'(hist.pop_back());
      m_press   = 4'b0000;
      m_release = 4'b0000;
      for (int i = 0; i < 4; i++) begin
        bit all_opp;
        all_opp = 1'b1;
        for (int j = 2; j <= D + 1; j++)
          if (hist[j][i] == m_boton[i]) all_opp = 1'b0;
        if (all_opp) begin
          m_boton[i] = ~m_boton[i];
          if (m_boton[i] != AL[i]) m_press[i] = 1'b1;
          else                     m_release[i] = 1'b1;
        end
      end
    end
  end

  // Per-cycle comparison against the model, on the falling edge.
  always @(negedge CLK) begin
    vectors++;
    if ({BOTON, PRESS, RELEASE} !== {m_boton, m_press, m_release}) begin
      miscompares++;
      $display("FAIL model_cycle t=%0t boton=%b press=%b release=%b expected boton=%b press=%b release=%b",
               $time, BOTON, PRESS, RELEASE, m_boton, m_press, m_release);
    end
    for (int i = 0; i < 4; i++) begin
      if (PRESS[i] === 1'b1)   press_seen[i]++;
      if (RELEASE[i] === 1'b1) release_seen[i]++;
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Wait n rising edges and land 1 time unit after the last one.
  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  int p0, p1, r1;

  initial begin
    for (int i = 0; i < 4; i++) begin
      press_seen[i]   = 0;
      release_seen[i] = 0;
    end

    // Reset with every input reading 0 (buttons 0-2 pressed, button 3 released)
    RSTN      = 1'b0;
    BOTON_RAW = 4'b0000;
    step(3);
    check("rst_boton", BOTON, 4'b0111);
    check("rst_press", PRESS, 4'b0000);
    check("rst_release", RELEASE, 4'b0000);
    RSTN = 1'b1;
    step(5);
    check("rst_qual_e5_boton", BOTON, 4'b0111);
    check("rst_qual_e5_press", PRESS, 4'b0000);
    step(1);
    check("rst_qual_e6_boton", BOTON, 4'b0000);
    check("rst_qual_e6_press", PRESS, 4'b0111);
    check("model_rst_qual_press", m_press, 4'b0111);
    step(1);
    check("rst_qual_e7_press", PRESS, 4'b0000);

    // Back to all released
    BOTON_RAW = 4'b0111;
    step(6);
    check("release_all", RELEASE, 4'b0111);
    check("release_all_boton", BOTON, 4'b0111);
    step(2);

    // Clean press on button 0
    BOTON_RAW = 4'b0110;
    step(5);
    check("clean_e5_boton", BOTON, 4'b0111);
    check("clean_e5_press", PRESS, 4'b0000);
    step(1);
    check("clean_e6_boton", BOTON, 4'b0110);
    check("clean_e6_press", PRESS, 4'b0001);
    check("clean_e6_release", RELEASE, 4'b0000);
    step(1);
    check("clean_e7_press", PRESS, 4'b0000);

    // Bounce on button 1 that never settles
    p1 = press_seen[1];
    r1 = release_seen[1];
    BOTON_RAW[1] = 1'b0; step(3);
    BOTON_RAW[1] = 1'b1; step(1);
    BOTON_RAW[1] = 1'b0; step(3);
    BOTON_RAW[1] = 1'b1; step(8);
    check("bounce_boton", BOTON, 4'b0110);
    check("bounce_press_cnt", press_seen[1] - p1, 0);
    check("bounce_release_cnt", release_seen[1] - r1, 0);

    // Same bounce, then low held for 10 cycles
    p1 = press_seen[1];
    BOTON_RAW[1] = 1'b0; step(3);
    BOTON_RAW[1] = 1'b1; step(1);
    BOTON_RAW[1] = 1'b0; step(3);
    BOTON_RAW[1] = 1'b1; step(1);
    BOTON_RAW[1] = 1'b0;
    step(5);
    check("settle_e5_boton", BOTON, 4'b0110);
    step(1);
    check("settle_e6_boton", BOTON, 4'b0100);
    check("settle_e6_press", PRESS, 4'b0010);
    check("model_settle_press", m_press, 4'b0010);
    step(4);
    check("settle_press_cnt", press_seen[1] - p1, 1);
    BOTON_RAW[1] = 1'b1;
    step(8);
    check("settle_released", BOTON, 4'b0110);

    // Active-high button 3: press then release
    BOTON_RAW[3] = 1'b1;
    step(5);
    check("ah_press_e5", PRESS, 4'b0000);
    step(1);
    check("ah_press_e6", PRESS, 4'b1000);
    check("ah_press_boton", BOTON, 4'b1110);
    step(1);
    check("ah_press_e7", PRESS, 4'b0000);
    step(2);
    BOTON_RAW[3] = 1'b0;
    step(5);
    check("ah_rel_e5", RELEASE, 4'b0000);
    step(1);
    check("ah_rel_e6", RELEASE, 4'b1000);
    check("ah_rel_boton", BOTON, 4'b0110);
    step(2);

    // Simultaneous press of buttons 0 and 2
    BOTON_RAW = 4'b0111;
    step(8);
    check("sim_pre_boton", BOTON, 4'b0111);
    BOTON_RAW = 4'b0010;
    step(6);
    check("sim_press", PRESS, 4'b0101);
    check("sim_boton", BOTON, 4'b0010);
    step(1);
    BOTON_RAW = 4'b0111;
    step(8);

    // Reset part-way through a confirm on button 0
    p0 = press_seen[0];
    BOTON_RAW = 4'b0110;
    step(3);
    RSTN = 1'b0;
    #1;
    check("midrst_boton", BOTON, 4'b0111);
    check("midrst_press", PRESS, 4'b0000);
    check("midrst_release", RELEASE, 4'b0000);
    step(6);
    check("midrst_no_strobe", press_seen[0] - p0, 0);
    RSTN = 1'b1;
    step(5);
    check("requal_e5_boton", BOTON, 4'b0111);
    step(1);
    check("requal_e6_press", PRESS, 4'b0001);
    check("requal_e6_boton", BOTON, 4'b0110);
    check("model_requal_press", m_press, 4'b0001);
    step(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
